dcache_flush_ctrl: RTL and testbench
====================================

DCACHE_FLUSH_CTRL -- requirements
Module: dcache_flush_ctrl

Interface
- REQ-001: Parameter NUM_SETS, default 256, number of cache sets swept; power of two, >=2.
- REQ-002: Parameter SET_ASSOC, default 8, number of ways.
- REQ-003: Parameter INDEX_W, default $clog2(NUM_SETS), set-index width.
- REQ-004: clk_i  in  1  single clock; all state updates on rising edge.
- REQ-005: rst_i  in  1  reset, synchronous, active-high.
- REQ-006: flush_i  in  1  flush request; held high until acknowledged.
- REQ-007: flush_ack_o  out  1  single-cycle pulse on flush completion.
- REQ-008: busy_o  out  1  high whenever state is not IDLE.
- REQ-009: req_o  out  SET_ASSOC  per-way SRAM request; all ways driven together.
- REQ-010: we_o  out  1  SRAM write enable (invalidate).
- REQ-011: addr_o  out  INDEX_W  set index under access.
- REQ-012: gnt_i  in  1  SRAM arbiter grant for the current request.
- REQ-013: valid_i, dirty_i  in  SET_ASSOC each  per-way state bits, valid the cycle after grant of a read.
- REQ-014: wb_req_o  out  1; wb_set_o  out  INDEX_W; wb_way_o  out  $clog2(SET_ASSOC)  write-back request to the miss handler.
- REQ-015: wb_gnt_i  in  1  write-back accepted; wb_done_i  in  1  write-back finished.

Function
- REQ-016: States IDLE, READ, CMP, WB, WB_WAIT, INVAL, DONE.
- REQ-017: IDLE: flush_i=1 -> READ, set counter := 0; otherwise stay.
- REQ-018: READ: req_o=all ones, we_o=0, addr_o=set; hold until gnt_i=1, then -> CMP.
- REQ-019: CMP: latch pending mask = valid_i & dirty_i; mask!=0 -> WB, else -> INVAL.
- REQ-020: WB: wb_req_o=1, wb_set_o=set, wb_way_o=index of lowest set bit of mask; hold all three stable until wb_gnt_i=1, then -> WB_WAIT.
- REQ-021: WB_WAIT: on wb_done_i clear that way's bit; remaining mask!=0 -> WB, else -> INVAL; wb_done_i in any other state ignored.
- REQ-022: INVAL: req_o=all ones, we_o=1, addr_o=set, valid/dirty write data 0; hold until gnt_i=1; then set==NUM_SETS-1 -> DONE, else set+1 -> READ.
- REQ-023: DONE: flush_ack_o=1 for exactly one cycle, -> IDLE.
- REQ-024: Set counter never wraps within a flush; a new flush restarts at set 0.
- REQ-025: flush_i deassertion while busy ignored; flush_i still high in the cycle after DONE starts a new flush.
- REQ-026: req_o, we_o, wb_req_o zero in IDLE, CMP, WB_WAIT, DONE; no SRAM request ever issued in the same cycle as wb_req_o.
- REQ-027: Clean cache, gnt_i tied 1: exactly 3 cycles per set; flush_ack_o in cycle 3*NUM_SETS+1 after flush_i is sampled in IDLE.

Reset
- REQ-028: rst_i=1 at any time: state := IDLE, set counter := 0, mask := 0; all outputs 0 in the following cycle.
- REQ-029: Reset mid-flush aborts the sweep; no flush_ack_o is generated for the aborted flush.

Configuration
- REQ-030: Macro DCACHE_FLUSH_PERF_EN defined: adds output flushed_lines_o (32-bit), cleared on flush start, +1 per wb_done_i accepted in WB_WAIT, saturating at 0xFFFFFFFF, reset to 0.
- REQ-031: Macro undefined: port and counter absent; all other behaviour identical.

Verification (NUM_SETS=4, SET_ASSOC=2)
- REQ-032: All valid/dirty 0, gnt_i=1, flush_i pulse -> addr_o sequence 0,1,2,3; flush_ack_o exactly in cycle 13; wb_req_o never high.
- REQ-033: Set 2 ways 0,1 valid+dirty, wb_gnt_i=1, wb_done_i 2 cycles after grant -> wb_way_o 0 then 1 with wb_set_o=2, then INVAL write to set 2; with DCACHE_FLUSH_PERF_EN flushed_lines_o=2.
- REQ-034: Way 1 valid not dirty on all sets -> no write-back; every set invalidated (we_o=1 once per set).
- REQ-035: gnt_i low 5 cycles during READ of set 1 -> req_o/addr_o held stable; ack delayed exactly 5 cycles vs REQ-032.
- REQ-036: rst_i asserted in WB_WAIT -> next cycle busy_o=0, wb_req_o=0; no flush_ack_o until a new flush completes.
- REQ-037: flush_i held high after ack -> second sweep starts from set 0 the cycle after DONE.

Source files
------------

// File: rtl/dcache_flush_ctrl.sv
// Data-cache flush sequencer: sweeps every set, writes back valid+dirty ways, then invalidates the set.
// Optional DCACHE_FLUSH_PERF_EN adds a saturating flushed_lines_o write-back counter.
module dcache_flush_ctrl #(
  parameter int NUM_SETS  = 256,
  parameter int SET_ASSOC = 8,
  parameter int INDEX_W   = $clog2(NUM_SETS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  output logic                         flush_ack_o,
  output logic                         busy_o,
  output logic [SET_ASSOC-1:0]         req_o,
  output logic                         we_o,
  output logic [INDEX_W-1:0]           addr_o,
  input  logic                         gnt_i,
  input  logic [SET_ASSOC-1:0]         valid_i,
  input  logic [SET_ASSOC-1:0]         dirty_i,
  output logic                         wb_req_o,
  output logic [INDEX_W-1:0]           wb_set_o,
  output logic [$clog2(SET_ASSOC)-1:0] wb_way_o,
  input  logic                         wb_gnt_i,
  input  logic                         wb_done_i
`ifdef DCACHE_FLUSH_PERF_EN
  ,
  output logic [31:0]                  flushed_lines_o
`endif
);

  localparam int WAY_W = $clog2(SET_ASSOC);
  localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(NUM_SETS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CMP,
    WB,
    WB_WAIT,
    INVAL,
    DONE
  } state_t;

  state_t               state, state_nxt;
  logic [INDEX_W-1:0]   set;
  logic [SET_ASSOC-1:0] mask;
  logic [SET_ASSOC-1:0] low_onehot;
  logic [WAY_W-1:0]     low_way;
  logic                 found;

  // Lowest pending way; stays put while its write-back is in flight.
  always_comb begin
    low_way    = '0;
    low_onehot = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < SET_ASSOC; i++) begin
      if (mask[i] && !found) begin
        low_way       = WAY_W'(i);
        low_onehot[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      set   <= '0;
      mask  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:    if (flush_i) set <= '0;
        CMP:     mask <= valid_i & dirty_i;
        WB_WAIT: if (wb_done_i) mask <= mask & ~low_onehot;
        INVAL:   if (gnt_i && set != LAST_SET) set <= set + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    busy_o      = (state != IDLE);
    req_o       = '0;
    we_o        = 1'b0;
    addr_o      = '0;
    wb_req_o    = 1'b0;
    wb_set_o    = '0;
    wb_way_o    = '0;
    flush_ack_o = 1'b0;
    case (state)
      IDLE: if (flush_i) state_nxt = READ;
      READ: begin
        req_o  = '1;
        addr_o = set;
        if (gnt_i) state_nxt = CMP;
      end
      CMP: state_nxt = ((valid_i & dirty_i) != '0) ? WB : INVAL;
      WB: begin
        wb_req_o = 1'b1;
        wb_set_o = set;
        wb_way_o = low_way;
        if (wb_gnt_i) state_nxt = WB_WAIT;
      end
      WB_WAIT: begin
        if (wb_done_i) state_nxt = ((mask & ~low_onehot) != '0) ? WB : INVAL;
      end
      INVAL: begin
        req_o  = '1;
        we_o   = 1'b1;
        addr_o = set;
        if (gnt_i) state_nxt = (set == LAST_SET) ? DONE : READ;
      end
      DONE: begin
        flush_ack_o = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DCACHE_FLUSH_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flushed_lines_o <= '0;
    end else if (state == IDLE && flush_i) begin
      flushed_lines_o <= '0;
    end else if (state == WB_WAIT && wb_done_i && flushed_lines_o != '1) begin
      flushed_lines_o <= flushed_lines_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Directed bench for dcache_flush_ctrl with NUM_SETS=4, SET_ASSOC=2 and a small tag-state SRAM model.
module tb_dcache_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst_i, flush_i, flush_ack_o, busy_o, we_o, gnt_i;
  logic [1:0] req_o, addr_o, valid_i, dirty_i, wb_set_o;
  logic       wb_req_o, wb_gnt_i, wb_done_i;
  logic [0:0] wb_way_o;
`ifdef DCACHE_FLUSH_PERF_EN
  logic [31:0] flushed_lines_o;
`endif

  dcache_flush_ctrl #(.NUM_SETS(4), .SET_ASSOC(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .flush_ack_o(flush_ack_o),
    .busy_o(busy_o), .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .gnt_i(gnt_i),
    .valid_i(valid_i), .dirty_i(dirty_i), .wb_req_o(wb_req_o), .wb_set_o(wb_set_o),
    .wb_way_o(wb_way_o), .wb_gnt_i(wb_gnt_i), .wb_done_i(wb_done_i)
`ifdef DCACHE_FLUSH_PERF_EN
    , .flushed_lines_o(flushed_lines_o)
`endif
  );

  always #5 clk = ~clk;

  // Tag-state SRAM model: read data follows the last granted read address.
  logic [1:0] vmem [4];
  logic [1:0] dmem [4];
  logic [1:0] rd_addr;
  assign valid_i = vmem[rd_addr];
  assign dirty_i = dmem[rd_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic       do_rd, do_wr;
    logic [1:0] a;
    do_rd = (req_o != '0) && gnt_i && !we_o;
    do_wr = (req_o != '0) && gnt_i && we_o;
    a     = addr_o;
    @(posedge clk);
    #1;
    if (do_rd) rd_addr = a;
    if (do_wr) begin
      vmem[a] = '0;
      dmem[a] = '0;
    end
  endtask

  // {busy, req[1:0], we, addr[1:0], wb_req, wb_set[1:0], wb_way, ack}
  function automatic logic [10:0] outs();
    return {busy_o, req_o, we_o, addr_o, wb_req_o, wb_set_o, wb_way_o, flush_ack_o};
  endfunction

  typedef struct {
    logic        flush;
    logic        done;
    logic [10:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic f, input logic d, input logic b, input logic [1:0] rq,
                              input logic w, input logic [1:0] ad, input logic wr,
                              input logic [1:0] ws, input logic ww, input logic ack);
    vec_t v;
    v.flush = f;
    v.done  = d;
    v.exp   = {b, rq, w, ad, wr, ws, ww, ack};
    return v;
  endfunction

  // Sweep monitor state
  int         ack_at, nreads;
  int         wr_set [4];
  logic [31:0] seq;
  bit         wb_seen, overlap;

  task automatic do_sweep(input int stall_set, input int stall_n, input int max_cyc);
    int  cyc, left;
    bit  pend;
    ack_at = -1; nreads = 0; seq = '0; wb_seen = 0; overlap = 0; pend = 0;
    left = stall_n;
    for (int i = 0; i < 4; i++) wr_set[i] = 0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    cyc = 1;
    while (cyc <= max_cyc && ack_at < 0) begin
      gnt_i     = 1'b1;
      wb_done_i = pend;
      if (req_o != '0 && !we_o && int'(addr_o) == stall_set && left > 0) begin
        gnt_i = 1'b0;
        left--;
      end
      if (req_o != '0 && gnt_i && !we_o) begin
        nreads++;
        seq = {seq[27:0], 2'b00, addr_o};
      end
      if (req_o != '0 && gnt_i && we_o) wr_set[addr_o]++;
      if (wb_req_o) wb_seen = 1;
      if (wb_req_o && req_o != '0) overlap = 1;
      if (flush_ack_o) ack_at = cyc;
      pend = wb_req_o && wb_gnt_i;
      tick();
      cyc++;
    end
    gnt_i = 1'b1;
    wb_done_i = 1'b0;
  endtask

  vec_t tbl [21];

  initial begin
    int  n;
    bit  hit;
    for (int i = 0; i < 4; i++) begin vmem[i] = '0; dmem[i] = '0; end
    rd_addr = '0;
    rst_i = 1'b1; flush_i = 1'b0; gnt_i = 1'b1; wb_gnt_i = 1'b1; wb_done_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    chk("reset_outputs", 64'(outs()), 64'h0);

    // Set 2 both ways valid+dirty; write-back done two cycles after each grant.
    vmem[2] = 2'b11; dmem[2] = 2'b11;
    tbl[0]  = mk(1, 0, 0, 2'b00, 0, 2'd0, 0, 2'd0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 2'b11, 0, 2'd0, 0, 2'd0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 2'b00, 0, 2'd0, 0, 2'd0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 2'b11, 1, 2'd0, 0, 2'd0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 2'b11, 0, 2'd1, 0, 2'd0, 0, 0);
    tbl[5]  = mk(0, 0, 1, 2'b00, 0, 2'd0, 0, 2'd0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 2'b11, 1, 2'd1, 0, 2'd0, 0, 0);
    tbl[7]  = mk(0, 0, 1, 2'b11, 0, 2'd2, 0, 2'd0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 2'b00, 0, 2'd0, 0, 2'd0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 2'b00, 0, 2'd0, 1, 2'd2, 0, 0);
    tbl[10] = mk(0, 0, 1, 2'b00, 0, 2'd0, 0, 2'd0, 0, 0);
    tbl[11] = mk(0, 1, 1, 2'b00, 0, 2'd0, 0, 2'd0, 0, 0);
    tbl[12] = mk(0, 0, 1, 2'b00, 0, 2'd0, 1, 2'd2, 1, 0);
    tbl[13] = mk(0, 0, 1, 2'b00, 0, 2'd0, 0, 2'd0, 0, 0);
    tbl[14] = mk(0, 1, 1, 2'b00, 0, 2'd0, 0, 2'd0, 0, 0);
    tbl[15] = mk(0, 0, 1, 2'b11, 1, 2'd2, 0, 2'd0, 0, 0);
    tbl[16] = mk(0, 0, 1, 2'b11, 0, 2'd3, 0, 2'd0, 0, 0);
    tbl[17] = mk(0, 0, 1, 2'b00, 0, 2'd0, 0, 2'd0, 0, 0);
    tbl[18] = mk(0, 0, 1, 2'b11, 1, 2'd3, 0, 2'd0, 0, 0);
    tbl[19] = mk(0, 0, 1, 2'b00, 0, 2'd0, 0, 2'd0, 0, 1);
    tbl[20] = mk(0, 0, 0, 2'b00, 0, 2'd0, 0, 2'd0, 0, 0);
    for (int i = 0; i < 21; i++) begin
      flush_i   = tbl[i].flush;
      wb_done_i = tbl[i].done;
      chk($sformatf("wb_vec[%0d]", i), 64'(outs()), 64'(tbl[i].exp));
      tick();
    end
    wb_done_i = 1'b0;
    chk("wb_set2_invalidated", 64'({vmem[2], dmem[2]}), 64'h0);
`ifdef DCACHE_FLUSH_PERF_EN
    chk("perf_two_lines", 64'(flushed_lines_o), 64'd2);
`endif

    // Clean cache, gnt tied high.
    do_sweep(-1, 0, 40);
    chk("clean_ack_cycle", 64'(ack_at), 64'd13);
    chk("clean_read_count", 64'(nreads), 64'd4);
    chk("clean_read_order", 64'(seq), 64'h0123);
    chk("clean_no_wb", 64'(wb_seen), 64'd0);

    // Way 1 valid but clean everywhere: invalidate only.
    for (int i = 0; i < 4; i++) begin vmem[i] = 2'b10; dmem[i] = 2'b00; end
    do_sweep(-1, 0, 40);
    chk("vnd_no_wb", 64'(wb_seen), 64'd0);
    chk("vnd_inval_each_set", 64'({wr_set[0][7:0], wr_set[1][7:0], wr_set[2][7:0], wr_set[3][7:0]}),
        64'h01010101);
    chk("vnd_valid_cleared", 64'({vmem[0], vmem[1], vmem[2], vmem[3]}), 64'h0);
    chk("vnd_ack_cycle", 64'(ack_at), 64'd13);

    // Five-cycle grant stall on the read of set 1.
    do_sweep(1, 5, 60);
    chk("stall_ack_cycle", 64'(ack_at), 64'd18);
    chk("stall_read_order", 64'(seq), 64'h0123);

    // Reset while waiting on a write-back for set 1.
    vmem[1] = 2'b01; dmem[1] = 2'b01;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (wb_req_o) hit = 1;
      tick();
    end
    chk("reached_wb_wait", 64'(hit), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_mid_outputs", 64'(outs()), 64'h0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (flush_ack_o) n++;
      tick();
    end
    chk("rst_no_ack", 64'(n), 64'd0);
    do_sweep(-1, 0, 40);
    chk("after_rst_ack_cycle", 64'(ack_at), 64'd15);
    chk("after_rst_wb_seen", 64'(wb_seen), 64'd1);
    chk("wb_no_sram_overlap", 64'(overlap), 64'd0);
`ifdef DCACHE_FLUSH_PERF_EN
    chk("perf_one_line", 64'(flushed_lines_o), 64'd1);
`endif

    // flush_i held high through completion restarts from set 0.
    flush_i = 1'b1;
    n = -1;
    for (int c = 0; c < 40 && n < 0; c++) begin
      if (flush_ack_o) n = c;
      else tick();
    end
    chk("held_ack_cycle", 64'(n), 64'd13);
    tick();
    chk("held_idle_after_done", 64'({busy_o, flush_ack_o}), 64'h0);
    tick();
    chk("held_restart_set0", 64'({busy_o, req_o, we_o, addr_o}), 64'({1'b1, 2'b11, 1'b0, 2'd0}));
    flush_i = 1'b0;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (flush_ack_o) hit = 1;
      tick();
    end
    chk("held_second_ack", 64'(hit), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
